// File: rtl/iir_deemph.sv
// First-order deemphasis IIR: y[n] = deq(b0*x[n]) + deq(b1*x[n-1]) + deq(a1*y[n-1]).
// One multiply-accumulate per cycle. Define IIR_SATURATE_EN to clamp the result instead of wrapping it.
module iir_deemph #(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     BITS       = 10,
  parameter logic [DATA_WIDTH-1:0]  X_COEFF0   = 32'h000000B2,
  parameter logic [DATA_WIDTH-1:0]  X_COEFF1   = 32'h000000B2,
  parameter logic [DATA_WIDTH-1:0]  Y_COEFF1   = 32'h0000029A
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full
);
  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = DW + 2;
  localparam int PW    = 2 * DW;
  localparam logic [PW-1:0] RND_ADD = PW'((64'd1 << BITS) - 64'd1);

  typedef enum logic [1:0] {READ, COMPUTE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     x_cur_q, x_cur_d, x_prev_q, x_prev_d, y_prev_q, y_prev_d;
  logic [DW-1:0]     y_out_q, y_out_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        mac_idx_q, mac_idx_d;

  logic [DW-1:0]     mul_a, mul_b, deq_v, result;
  logic [PW-1:0]     prod, rnd, shifted;

  // Operand select for the current MAC step; index 3 never occurs.
  always_comb begin
    case (mac_idx_q)
      2'd0:    begin mul_a = X_COEFF0; mul_b = x_cur_q;  end
      2'd1:    begin mul_a = X_COEFF1; mul_b = x_prev_q; end
      default: begin mul_a = Y_COEFF1; mul_b = y_prev_q; end
    endcase
  end

  // Signed product; negative values get a bias so the shift rounds toward zero.
  assign prod    = {{DW{mul_a[DW-1]}}, mul_a} * {{DW{mul_b[DW-1]}}, mul_b};
  assign rnd     = prod + (prod[PW-1] ? RND_ADD : '0);
  assign shifted = PW'($signed(rnd) >>> BITS);
  assign deq_v   = shifted[DW-1:0];

`ifdef IIR_SATURATE_EN
  logic acc_ovf;
  logic unused_prod_hi;
  assign acc_ovf        = !((&acc_q[ACC_W-1:DW-1]) || !(|acc_q[ACC_W-1:DW-1]));
  assign result         = !acc_ovf       ? acc_q[DW-1:0] :
                          acc_q[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  assign unused_prod_hi = ^shifted[PW-1:DW];
`else
  logic unused_hi;
  assign result    = acc_q[DW-1:0];
  assign unused_hi = ^{acc_q[ACC_W-1:DW], shifted[PW-1:DW]};
`endif

  always_comb begin
    state_d     = state_q;
    x_cur_d     = x_cur_q;
    x_prev_d    = x_prev_q;
    y_prev_d    = y_prev_q;
    y_out_d     = y_out_q;
    acc_d       = acc_q;
    mac_idx_d   = mac_idx_q;
    x_in_rd_en  = 1'b0;
    y_out_wr_en = 1'b0;
    y_out       = y_out_q;
    case (state_q)
      READ: begin
        x_in_rd_en = !x_in_empty && reset;
        if (!x_in_empty) begin
          x_cur_d   = x_in;
          acc_d     = '0;
          mac_idx_d = 2'd0;
          state_d   = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d     = acc_q + {{2{deq_v[DW-1]}}, deq_v};
        mac_idx_d = mac_idx_q + 2'd1;
        if (mac_idx_q == 2'd2) state_d = WRITE;
      end
      WRITE: begin
        y_out       = result;
        y_out_wr_en = !y_out_full && reset;
        // History moves only on a real push so a stall cannot corrupt state.
        if (!y_out_full) begin
          y_out_d  = result;
          x_prev_d = x_cur_q;
          y_prev_d = result;
          state_d  = READ;
        end
      end
      default: state_d = READ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= READ;
      x_cur_q   <= '0;
      x_prev_q  <= '0;
      y_prev_q  <= '0;
      y_out_q   <= '0;
      acc_q     <= '0;
      mac_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      x_cur_q   <= x_cur_d;
      x_prev_q  <= x_prev_d;
      y_prev_q  <= y_prev_d;
      y_out_q   <= y_out_d;
      acc_q     <= acc_d;
      mac_idx_q <= mac_idx_d;
    end
  end
endmodule

// File: tb/tb_iir_deemph.sv
// Bench for iir_deemph: vector table, corner sequences, and a random run scored against an arithmetic model.
module tb_iir_deemph;
  logic        clock = 1'b0, reset = 1'b0;
  logic [31:0] x_in = '0;
  logic        x_in_empty = 1'b1, y_out_full = 1'b0;
  logic        x_in_rd_en, y_out_wr_en, x_in_rd_en2, y_out_wr_en2;
  logic [31:0] y_out, y_out2;
  int          checks = 0, errors = 0, cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  iir_deemph dut (
    .clock(clock), .reset(reset), .x_in(x_in), .x_in_rd_en(x_in_rd_en),
    .x_in_empty(x_in_empty), .y_out(y_out), .y_out_wr_en(y_out_wr_en), .y_out_full(y_out_full));

  // Unity feed-forward, no feedback: exposes accumulator overflow handling.
  iir_deemph #(.X_COEFF0(32'd1024), .X_COEFF1(32'd1024), .Y_COEFF1(32'd0)) dut_ovf (
    .clock(clock), .reset(reset), .x_in(x_in), .x_in_rd_en(x_in_rd_en2),
    .x_in_empty(x_in_empty), .y_out(y_out2), .y_out_wr_en(y_out_wr_en2), .y_out_full(y_out_full));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0; x_in_empty = 1'b1; y_out_full = 1'b0;
    @(negedge clock); reset = 1'b1;
  endtask

  // Push one sample, optionally holding full through `stall` WRITE cycles; returns y and pop-to-push cycles.
  task automatic do_sample(input logic [31:0] x, input int stall,
                           output logic [31:0] y, output logic [31:0] y2, output int lat);
    int t0; bit got; bit bad;
    y = 'x; y2 = 'x; lat = -1; bad = 0;
    @(negedge clock); x_in = x; x_in_empty = 1'b0; y_out_full = (stall > 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1; if (x_in_rd_en) got = 1; else @(negedge clock);
    end
    if (!got) begin errors++; $display("FAIL pop_timeout: no pop for x=%0h", x); return; end
    t0 = cyc;
    @(negedge clock); x_in_empty = 1'b1;
    for (int i = 0; i < 2 + stall; i++) begin
      #1; if (x_in_rd_en || y_out_wr_en) bad = 1;
      @(negedge clock);
    end
    if (stall > 0) begin
      #1; if (x_in_rd_en || y_out_wr_en) bad = 1;
      chk("strobes_while_stalled", {31'd0, bad}, 32'd0);
      @(negedge clock); y_out_full = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1; if (y_out_wr_en) got = 1; else @(negedge clock);
    end
    if (!got) begin errors++; $display("FAIL push_timeout: no push for x=%0h", x); return; end
    y = y_out; y2 = y_out2; lat = cyc - t0;
  endtask

  // Reference: longint division truncates toward zero, exactly the required rounding.
  function automatic int deq(input longint p);
    return int'(p / 1024);
  endfunction

  function automatic int reduce(input longint s);
`ifdef IIR_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return int'(s);
  endfunction

  int m_xp, m_yp;
  function automatic int model_step(input int x);
    longint s;
    int y;
    s = longint'(deq(longint'(x) * 178)) + longint'(deq(longint'(m_xp) * 178))
      + longint'(deq(longint'(m_yp) * 666));
    y = reduce(s);
    m_xp = x; m_yp = y;
    return y;
  endfunction

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          stall;
    bit          rst_before;
  } vec_t;

  initial begin
    vec_t        tbl[7];
    logic [31:0] y, y2;
    int          lat;
    int          xs[100];
    int          expq[$];
    int          idx, nout;
    bit          viol;

    tbl[0] = '{32'd1024,     32'd178,     0, 1'b0};
    tbl[1] = '{32'd0,        32'd293,     0, 1'b0};
    tbl[2] = '{32'd0,        32'd190,     0, 1'b0};
    tbl[3] = '{-32'sd1024,   -32'sd178,   0, 1'b1};
    tbl[4] = '{32'd1024,     32'd178,    10, 1'b1};
    tbl[5] = '{32'd0,        32'd293,     0, 1'b0};
    tbl[6] = '{32'd0,        32'd190,     0, 1'b0};

    // Reset state, with the FIFO offering data so a leaking strobe would show.
    x_in_empty = 1'b0; #12;
    chk("reset_rd_en", {31'd0, x_in_rd_en}, 32'd0);
    chk("reset_wr_en", {31'd0, y_out_wr_en}, 32'd0);
    chk("reset_y_out", y_out, 32'd0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst_before) do_reset();
      do_sample(tbl[i].x, tbl[i].stall, y, y2, lat);
      chk($sformatf("vec%0d_y", i), y, tbl[i].y);
      chk($sformatf("vec%0d_latency", i), lat, 32'(4 + tbl[i].stall));
    end

    // Reset pulsed during COMPUTE: strobes and y_out clear at once, histories are gone.
    @(negedge clock); x_in = 32'd5000; x_in_empty = 1'b0;
    @(negedge clock); x_in_empty = 1'b1;
    @(negedge clock); reset = 1'b0; x_in_empty = 1'b0; #1;
    chk("midrst_rd_en", {31'd0, x_in_rd_en}, 32'd0);
    chk("midrst_wr_en", {31'd0, y_out_wr_en}, 32'd0);
    chk("midrst_y_out", y_out, 32'd0);
    @(negedge clock); x_in_empty = 1'b1; reset = 1'b1;
    do_sample(32'd1024, 0, y, y2, lat);
    chk("midrst_impulse", y, 32'd178);

    // Overflow: 2^30 + 2^30 exceeds the signed 32-bit range.
    do_reset();
    do_sample(32'h40000000, 0, y, y2, lat);
    chk("ovf_first", y2, 32'h40000000);
    do_sample(32'h40000000, 0, y, y2, lat);
`ifdef IIR_SATURATE_EN
    chk("ovf_second", y2, 32'h7FFFFFFF);
`else
    chk("ovf_second", y2, 32'h80000000);
`endif

    // Random starvation and backpressure against the model.
    do_reset();
    m_xp = 0; m_yp = 0;
    for (int i = 0; i < 100; i++) xs[i] = int'($urandom_range(0, 32'h3FFFFFFF)) - 32'sh20000000;
    idx = 0; nout = 0; viol = 0;
    for (int c = 0; c < 5000 && nout < 100; c++) begin
      @(negedge clock);
      x_in_empty = (idx >= 100) ? 1'b1 : ($urandom_range(0, 2) == 0);
      x_in       = (idx < 100) ? xs[idx] : 32'd0;
      y_out_full = ($urandom_range(0, 3) == 0);
      #1;
      if (x_in_rd_en) begin
        if (x_in_empty) viol = 1;
        expq.push_back(model_step(xs[idx]));
        idx++;
      end
      if (y_out_wr_en) begin
        if (y_out_full) viol = 1;
        if (expq.size() == 0) viol = 1;
        else chk($sformatf("rand_y%0d", nout), y_out, expq.pop_front());
        nout++;
      end
    end
    chk("rand_outputs", nout, 32'd100);
    chk("rand_flag_rules", {31'd0, viol}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
